// File: rtl/nand_cmd_dispatch.sv
// Per-way command dispatcher: request FIFO, single-outstanding issue over the
// cmd/ack/ready handshake, status capture and tagged completion with error flags.
`ifndef CMD_WD
`define CMD_WD 4
`endif
`ifndef NADDR_WD
`define NADDR_WD 40
`endif
`ifndef CIO_WD
`define CIO_WD 8
`endif
`ifndef CMD_RESET
`define CMD_RESET 4'h1
`endif
`ifndef CMD_MODE_CHANGE
`define CMD_MODE_CHANGE 4'h2
`endif

module nand_cmd_dispatch #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int CMD_W  = `CMD_WD,
    parameter int ADDR_W = `NADDR_WD,
    parameter int ST_W   = `CIO_WD,
    parameter int ACK_TO = 16
) (
    input  logic                     i_nc_clk,
    input  logic                     i_nc_rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [TAG_W-1:0]         i_req_tag,
    input  logic [CMD_W-1:0]         i_req_cmd,
    input  logic [ADDR_W-1:0]        i_req_addr,
    output logic [CMD_W-1:0]         o_command,
    output logic                     o_cmd_ack,
    output logic [ADDR_W-1:0]        o_nand_addr,
    input  logic                     i_maddr_ack,
    input  logic                     i_ready,
    input  logic [ST_W-1:0]          i_status,
    output logic                     o_cpl_valid,
    input  logic                     i_cpl_ready,
    output logic [TAG_W-1:0]         o_cpl_tag,
    output logic [ST_W-1:0]          o_cpl_status,
    output logic [1:0]               o_cpl_err,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_q_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(ACK_TO) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_CAPT,
        S_CPLT
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                seen_q, seen_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ack_q, ack_d;
    logic                cpl_valid_q, cpl_valid_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [ST_W-1:0]     status_q, status_d;
    logic [1:0]          err_q, err_d;

    logic [TAG_W-1:0]    tag_mem  [DEPTH];
    logic [CMD_W-1:0]    cmd_mem  [DEPTH];
    logic [ADDR_W-1:0]   addr_mem [DEPTH];

    logic                push;
    logic                pop;
    logic                no_addr_cmd;

    assign o_req_ready  = (cnt_q != CNT_W'(DEPTH));
    assign push         = i_req_valid & o_req_ready;
    // Reset and mode-change never present an address, so no maddr_ack is expected.
    assign no_addr_cmd  = (cmd_q == CMD_W'(`CMD_RESET)) || (cmd_q == CMD_W'(`CMD_MODE_CHANGE));

    assign o_command    = cmd_q;
    assign o_cmd_ack    = ack_q;
    assign o_nand_addr  = addr_q;
    assign o_cpl_valid  = cpl_valid_q;
    assign o_cpl_tag    = tag_q;
    assign o_cpl_status = status_q;
    assign o_cpl_err    = err_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_q_cnt      = cnt_q;

    always_ff @(posedge i_nc_clk) begin
        if (push) begin
            tag_mem[wr_ptr_q]  <= i_req_tag;
            cmd_mem[wr_ptr_q]  <= i_req_cmd;
            addr_mem[wr_ptr_q] <= i_req_addr;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        tag_d       = tag_q;
        status_d    = status_q;
        err_d       = err_q;
        ack_d       = ack_q;
        cpl_valid_d = cpl_valid_q;
        seen_d      = seen_q;
        to_d        = to_q;
        pop         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if ((cnt_q != '0) && i_ready) begin
                    pop     = 1'b1;
                    cmd_d   = cmd_mem[rd_ptr_q];
                    addr_d  = addr_mem[rd_ptr_q];
                    tag_d   = tag_mem[rd_ptr_q];
                    err_d   = '0;
                    seen_d  = 1'b0;
                    to_d    = '0;
                    ack_d   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_maddr_ack) begin
                    seen_d = 1'b1;
                end
                if (!i_ready) begin
                    ack_d   = 1'b0;
                    state_d = S_BUSY;
                end else if (to_q == TO_W'(ACK_TO - 1)) begin
                    ack_d       = 1'b0;
                    err_d[0]    = 1'b1;
                    status_d    = '0;
                    cpl_valid_d = 1'b1;
                    state_d     = S_CPLT;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_BUSY: begin
                if (i_maddr_ack) begin
                    seen_d = 1'b1;
                end
                if (i_ready) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                status_d    = i_status;
                if (!no_addr_cmd && !seen_q) begin
                    err_d[1] = 1'b1;
                end
                cpl_valid_d = 1'b1;
                state_d     = S_CPLT;
            end
            S_CPLT: begin
                if (i_cpl_ready) begin
                    cpl_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_nc_clk) begin
        if (i_nc_rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            to_q        <= '0;
            seen_q      <= 1'b0;
            cmd_q       <= '0;
            addr_q      <= '0;
            ack_q       <= 1'b0;
            cpl_valid_q <= 1'b0;
            tag_q       <= '0;
            status_q    <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            seen_q      <= seen_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            ack_q       <= ack_d;
            cpl_valid_q <= cpl_valid_d;
            tag_q       <= tag_d;
            status_q    <= status_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_nand_cmd_dispatch.sv
// Self-checking bench for nand_cmd_dispatch: directed scenarios plus randomized
// traffic compared against a queue-based completion model.
`ifndef CMD_WD
`define CMD_WD 4
`endif
`ifndef NADDR_WD
`define NADDR_WD 40
`endif
`ifndef CIO_WD
`define CIO_WD 8
`endif
`ifndef CMD_RESET
`define CMD_RESET 4'h1
`endif
`ifndef CMD_MODE_CHANGE
`define CMD_MODE_CHANGE 4'h2
`endif

module tb_nand_cmd_dispatch;

    localparam int DEPTH = 4;
    localparam int ACK_TO = 16;
    localparam logic [3:0] C_RESET = `CMD_RESET;
    localparam logic [3:0] C_MODE  = `CMD_MODE_CHANGE;
    localparam logic [3:0] C_READ  = 4'h3;
    localparam logic [3:0] C_PROG  = 4'h4;

    typedef struct {
        logic [3:0]  tag;
        logic [3:0]  cmd;
        logic [39:0] addr;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [3:0]  i_req_tag = '0;
    logic [3:0]  i_req_cmd = '0;
    logic [39:0] i_req_addr = '0;
    logic [3:0]  o_command;
    logic        o_cmd_ack;
    logic [39:0] o_nand_addr;
    logic        i_maddr_ack = 1'b0;
    logic        i_ready = 1'b0;
    logic [7:0]  i_status = '0;
    logic        o_cpl_valid;
    logic        i_cpl_ready = 1'b0;
    logic [3:0]  o_cpl_tag;
    logic [7:0]  o_cpl_status;
    logic [1:0]  o_cpl_err;
    logic        o_busy;
    logic [2:0]  o_q_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    req_t model_q[$];

    nand_cmd_dispatch #(
        .DEPTH(DEPTH), .TAG_W(4), .CMD_W(4), .ADDR_W(40), .ST_W(8), .ACK_TO(ACK_TO)
    ) dut (
        .i_nc_clk(clk), .i_nc_rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_tag(i_req_tag), .i_req_cmd(i_req_cmd), .i_req_addr(i_req_addr),
        .o_command(o_command), .o_cmd_ack(o_cmd_ack), .o_nand_addr(o_nand_addr),
        .i_maddr_ack(i_maddr_ack), .i_ready(i_ready), .i_status(i_status),
        .o_cpl_valid(o_cpl_valid), .i_cpl_ready(i_cpl_ready),
        .o_cpl_tag(o_cpl_tag), .o_cpl_status(o_cpl_status), .o_cpl_err(o_cpl_err),
        .o_busy(o_busy), .o_q_cnt(o_q_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] tag, input logic [3:0] cmd,
                        input logic [39:0] addr, output bit acc);
        i_req_valid = 1'b1;
        i_req_tag   = tag;
        i_req_cmd   = cmd;
        i_req_addr  = addr;
        acc = (o_req_ready === 1'b1);
        tick();
        i_req_valid = 1'b0;
    endtask

    task automatic accept();
        i_cpl_ready = 1'b1;
        tick();
        i_cpl_ready = 1'b0;
    endtask

    // Plays the way controller for one command and returns the completion seen.
    task automatic run_cmd(input bit to_mode, input bit maddr, input int blen,
                           input logic [7:0] st, output logic [3:0] tag,
                           output logic [7:0] stat, output logic [1:0] err,
                           output int acks, output bit ok);
        int w;
        ok = 1'b1; acks = 0; tag = '0; stat = '0; err = '0;
        i_ready = 1'b1;
        w = 0;
        while (o_cmd_ack !== 1'b1 && w < 50) begin tick(); w++; end
        if (o_cmd_ack !== 1'b1) begin ok = 1'b0; return; end
        acks = 1;
        if (to_mode) begin
            w = 0;
            while (w < 40) begin
                tick(); w++;
                if (o_cmd_ack === 1'b1) acks++;
                else break;
            end
        end else begin
            tick();
            if (o_cmd_ack === 1'b1) acks++;
            i_ready = 1'b0;
            i_maddr_ack = maddr;
            tick();
            if (o_cmd_ack === 1'b1) acks++;
            i_maddr_ack = 1'b0;
            repeat (blen) tick();
            i_status = st;
            i_ready = 1'b1;
        end
        w = 0;
        while (o_cpl_valid !== 1'b1 && w < 100) begin tick(); w++; end
        if (o_cpl_valid !== 1'b1) begin ok = 1'b0; return; end
        tag = o_cpl_tag; stat = o_cpl_status; err = o_cpl_err;
    endtask

    function automatic logic [1:0] exp_err(input bit to_mode, input logic [3:0] cmd, input bit maddr);
        if (to_mode) return 2'b01;
        if (cmd != C_RESET && cmd != C_MODE && !maddr) return 2'b10;
        return 2'b00;
    endfunction

    task automatic test_reset();
        rst = 1'b1; i_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_cmp++;
        if ({o_cmd_ack, o_cpl_valid, o_cpl_err, o_busy, o_q_cnt, o_req_ready} !== 9'b0_0_00_0_000_1) begin
            n_bad++;
            $display("FAIL reset_ctrl: got ack=%b cv=%b err=%b busy=%b cnt=%0d rdy=%b, required 0 0 00 0 0 1",
                     o_cmd_ack, o_cpl_valid, o_cpl_err, o_busy, o_q_cnt, o_req_ready);
        end
        n_cmp++;
        if ({o_command, o_nand_addr, o_cpl_tag, o_cpl_status} !== 56'd0) begin
            n_bad++;
            $display("FAIL reset_data: got cmd=%h addr=%h tag=%h st=%h, required all 0",
                     o_command, o_nand_addr, o_cpl_tag, o_cpl_status);
        end
    endtask

    task automatic test_single_read();
        bit acc, ok; logic [3:0] tg; logic [7:0] st; logic [1:0] er; int acks;
        i_ready = 1'b1;
        push(4'd3, C_READ, 40'h12_3456_7800, acc);
        n_cmp++;
        if (o_cmd_ack !== 1'b0) begin
            n_bad++; $display("FAIL read_no_fallthrough: ack=%b, required 0", o_cmd_ack);
        end
        tick();
        n_cmp++;
        if (o_cmd_ack !== 1'b1) begin
            n_bad++; $display("FAIL read_ack_latency: ack=%b at cycle 2, required 1", o_cmd_ack);
        end
        run_cmd(1'b0, 1'b1, 50, 8'hE0, tg, st, er, acks, ok);
        n_cmp++;
        if (!ok || acks != 2 || tg !== 4'd3 || st !== 8'hE0 || er !== 2'b00) begin
            n_bad++;
            $display("FAIL read_cpl: ok=%b acks=%0d tag=%0d st=%h err=%b, required 1 2 3 e0 00",
                     ok, acks, tg, st, er);
        end
        accept();
        n_cmp++;
        if (o_cpl_valid !== 1'b0 || o_command !== C_READ || o_nand_addr !== 40'h12_3456_7800) begin
            n_bad++;
            $display("FAIL read_hold: cv=%b cmd=%h addr=%h, required 0 %h 1234567800",
                     o_cpl_valid, o_command, o_nand_addr, C_READ);
        end
    endtask

    task automatic test_no_maddr();
        bit acc, ok; logic [3:0] tg; logic [7:0] st; logic [1:0] er; int acks;
        i_ready = 1'b0;
        push(4'd5, C_RESET, 40'h0, acc);
        run_cmd(1'b0, 1'b0, 5, 8'hC0, tg, st, er, acks, ok);
        n_cmp++;
        if (!ok || tg !== 4'd5 || st !== 8'hC0 || er !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_cmd_err: ok=%b tag=%0d st=%h err=%b, required 1 5 c0 00", ok, tg, st, er);
        end
        accept();
        i_ready = 1'b0;
        push(4'd6, C_PROG, 40'hAB_CDEF_0123, acc);
        run_cmd(1'b0, 1'b0, 5, 8'hE1, tg, st, er, acks, ok);
        n_cmp++;
        if (!ok || tg !== 4'd6 || st !== 8'hE1 || er !== 2'b10) begin
            n_bad++;
            $display("FAIL prog_no_maddr_err: ok=%b tag=%0d st=%h err=%b, required 1 6 e1 10", ok, tg, st, er);
        end
        accept();
    endtask

    task automatic test_timeout();
        bit acc, ok; logic [3:0] tg; logic [7:0] st; logic [1:0] er; int acks;
        i_ready = 1'b0;
        i_status = 8'hFF;
        push(4'd9, C_READ, 40'h55, acc);
        run_cmd(1'b1, 1'b0, 0, 8'h00, tg, st, er, acks, ok);
        n_cmp++;
        if (!ok || acks != ACK_TO || tg !== 4'd9 || st !== 8'h00 || er !== 2'b01) begin
            n_bad++;
            $display("FAIL timeout_cpl: ok=%b acks=%0d tag=%0d st=%h err=%b, required 1 %0d 9 00 01",
                     ok, acks, tg, st, er, ACK_TO);
        end
        accept();
        n_cmp++;
        if (o_busy !== 1'b0 || o_cpl_valid !== 1'b0) begin
            n_bad++; $display("FAIL timeout_idle: busy=%b cv=%b, required 0 0", o_busy, o_cpl_valid);
        end
    endtask

    task automatic test_fifo_order();
        bit acc, ok; logic [3:0] tg; logic [7:0] st; logic [1:0] er; int acks; int n_acc;
        i_ready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            push(4'(k), C_RESET, 40'(k), acc);
            if (acc) n_acc++;
            if (k == 4) begin
                n_cmp++;
                if (acc) begin
                    n_bad++; $display("FAIL fifo_5th_refused: accepted=1, required 0");
                end
            end
        end
        n_cmp++;
        if (n_acc != 4 || o_q_cnt !== 3'd4 || o_req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL fifo_full: accepted=%0d cnt=%0d rdy=%b, required 4 4 0", n_acc, o_q_cnt, o_req_ready);
        end
        i_ready = 1'b1;
        push(4'd7, C_RESET, 40'h0, acc);
        n_cmp++;
        if (acc || o_q_cnt !== 3'd3 || o_cmd_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL fifo_push_at_pop: accepted=%b cnt=%0d ack=%b, required 0 3 1", acc, o_q_cnt, o_cmd_ack);
        end
        for (int k = 0; k < 4; k++) begin
            run_cmd(1'b0, 1'b0, 2, 8'(k), tg, st, er, acks, ok);
            n_cmp++;
            if (!ok || tg !== 4'(k) || st !== 8'(k) || er !== 2'b00) begin
                n_bad++;
                $display("FAIL fifo_order_%0d: ok=%b tag=%0d st=%h err=%b, required 1 %0d %h 00",
                         k, ok, tg, st, er, k, 8'(k));
            end
            accept();
        end
    endtask

    task automatic test_back_to_back();
        bit acc, ok; logic [3:0] tg; logic [7:0] st; logic [1:0] er; int acks;
        i_ready = 1'b0;
        push(4'd10, C_PROG, 40'h77, acc);
        push(4'd11, C_MODE, 40'h88, acc);
        run_cmd(1'b0, 1'b1, 3, 8'hA5, tg, st, er, acks, ok);
        n_cmp++;
        if (!ok || tg !== 4'd10 || st !== 8'hA5 || er !== 2'b00) begin
            n_bad++;
            $display("FAIL bp_first: ok=%b tag=%0d st=%h err=%b, required 1 10 a5 00", ok, tg, st, er);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            n_cmp++;
            if (o_cpl_valid !== 1'b1 || o_cpl_tag !== 4'd10 || o_cpl_status !== 8'hA5 ||
                o_cpl_err !== 2'b00 || o_cmd_ack !== 1'b0 || o_command !== C_PROG) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: cv=%b tag=%0d st=%h err=%b ack=%b cmd=%h, required 1 10 a5 00 0 %h",
                         k, o_cpl_valid, o_cpl_tag, o_cpl_status, o_cpl_err, o_cmd_ack, o_command, C_PROG);
            end
        end
        accept();
        n_cmp++;
        if (o_cmd_ack !== 1'b0 || o_cpl_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_accept_cycle: ack=%b cv=%b, required 0 0", o_cmd_ack, o_cpl_valid);
        end
        tick();
        n_cmp++;
        if (o_cmd_ack !== 1'b1 || o_command !== C_MODE || o_nand_addr !== 40'h88) begin
            n_bad++;
            $display("FAIL bp_next_issue: ack=%b cmd=%h addr=%h, required 1 %h 88", o_cmd_ack, o_command, o_nand_addr, C_MODE);
        end
        run_cmd(1'b0, 1'b0, 2, 8'h3C, tg, st, er, acks, ok);
        n_cmp++;
        if (!ok || acks != 2 || tg !== 4'd11 || st !== 8'h3C || er !== 2'b00) begin
            n_bad++;
            $display("FAIL bp_second: ok=%b acks=%0d tag=%0d st=%h err=%b, required 1 2 11 3c 00", ok, acks, tg, st, er);
        end
        accept();
    endtask

    task automatic test_reset_busy();
        bit acc; int w; bit seen;
        i_ready = 1'b1;
        push(4'd12, C_READ, 40'h99, acc);
        w = 0;
        while (o_cmd_ack !== 1'b1 && w < 20) begin tick(); w++; end
        i_ready = 1'b0;
        tick();
        push(4'd13, C_READ, 40'h9A, acc);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (o_q_cnt !== 3'd0 || o_busy !== 1'b0 || o_cpl_valid !== 1'b0 || o_cmd_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_busy: cnt=%0d busy=%b cv=%b ack=%b, required 0 0 0 0",
                     o_q_cnt, o_busy, o_cpl_valid, o_cmd_ack);
        end
        i_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (o_cpl_valid === 1'b1 || o_cmd_ack === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++; $display("FAIL rst_no_cpl: activity=1, required 0");
        end
    endtask

    task automatic test_random();
        bit acc, ok, to_mode, maddr; logic [3:0] tg; logic [7:0] st, rs; logic [1:0] er;
        int acks, n, blen; req_t r, e;
        logic [3:0] cmds [4];
        cmds[0] = C_RESET; cmds[1] = C_MODE; cmds[2] = C_READ; cmds[3] = C_PROG;
        for (int round = 0; round < 8; round++) begin
            i_ready = 1'b0;
            n = int'($urandom_range(1, 3));
            for (int k = 0; k < n; k++) begin
                r.tag  = 4'($urandom);
                r.cmd  = cmds[$urandom_range(0, 3)];
                r.addr = {8'($urandom), 32'($urandom)};
                push(r.tag, r.cmd, r.addr, acc);
                if (acc) model_q.push_back(r);
            end
            while (model_q.size() > 0) begin
                e = model_q.pop_front();
                to_mode = ($urandom_range(0, 3) == 0);
                maddr   = 1'($urandom);
                blen    = int'($urandom_range(1, 8));
                rs      = 8'($urandom);
                run_cmd(to_mode, maddr, blen, rs, tg, st, er, acks, ok);
                n_cmp++;
                if (!ok || tg !== e.tag || st !== (to_mode ? 8'h00 : rs) ||
                    er !== exp_err(to_mode, e.cmd, maddr) || acks != (to_mode ? ACK_TO : 2) ||
                    o_command !== e.cmd || o_nand_addr !== e.addr) begin
                    n_bad++;
                    $display("FAIL rand_r%0d: ok=%b tag=%0d st=%h err=%b acks=%0d cmd=%h addr=%h, required tag=%0d st=%h err=%b acks=%0d cmd=%h addr=%h",
                             round, ok, tg, st, er, acks, o_command, o_nand_addr, e.tag,
                             (to_mode ? 8'h00 : rs), exp_err(to_mode, e.cmd, maddr),
                             (to_mode ? ACK_TO : 2), e.cmd, e.addr);
                end
                accept();
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_no_maddr();
        test_timeout();
        test_fifo_order();
        test_back_to_back();
        test_reset_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
